// File: rtl/counter_checker.sv
// counter_checker
//   Passive monitor for a free-running up-counter. It samples the counter's
//   enable and count output on every rising clock edge and predicts the value
//   for the next edge as in + enable (mod 2^BITS). It flags mismatches and
//   keeps saturating counts of errors and of all-ones -> 0 wrap-arounds.
//   All outputs are registered, so the effect of a sample appears one cycle later.
//
// Parameters
//   BITS       width of the monitored count
//   ERR_BITS   width of the saturating error counter
//   WRAP_BITS  width of the saturating wrap-around counter
//   STICKY     1: first mismatch latches fault until reset; 0: resync and continue
//
// Ports
//   clock        in   rising-edge clock shared with the counter
//   reset        in   asynchronous, active-high; clears all state
//   enable       in   enable driven into the counter
//   in           in   counter output under check
//   synced       out  1 once a reference value has been captured
//   error        out  one-cycle pulse per detected mismatch
//   fault        out  1 while latched in the fault state (STICKY=1 only)
//   error_count  out  mismatches since reset, saturating
//   wrap_count   out  all-ones -> 0 transitions seen, saturating
//   expected     out  value predicted for the next sampled edge

module counter_checker #(
    parameter int BITS      = 2,
    parameter int ERR_BITS  = 8,
    parameter int WRAP_BITS = 8,
    parameter int STICKY    = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [BITS-1:0]      in,
    output logic                 synced,
    output logic                 error,
    output logic                 fault,
    output logic [ERR_BITS-1:0]  error_count,
    output logic [WRAP_BITS-1:0] wrap_count,
    output logic [BITS-1:0]      expected
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t               state, state_n;
    logic                 synced_n;
    logic                 error_n;
    logic                 fault_n;
    logic [ERR_BITS-1:0]  error_count_n;
    logic [WRAP_BITS-1:0] wrap_count_n;
    logic [BITS-1:0]      expected_n;
    logic [BITS-1:0]      predict;

    assign predict = in + BITS'(enable);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= SYNC;
            synced      <= 1'b0;
            error       <= 1'b0;
            fault       <= 1'b0;
            error_count <= '0;
            wrap_count  <= '0;
            expected    <= '0;
        end else begin
            state       <= state_n;
            synced      <= synced_n;
            error       <= error_n;
            fault       <= fault_n;
            error_count <= error_count_n;
            wrap_count  <= wrap_count_n;
            expected    <= expected_n;
        end
    end

    always_comb begin
        state_n       = state;
        synced_n      = synced;
        error_n       = 1'b0;
        fault_n       = fault;
        error_count_n = error_count;
        wrap_count_n  = wrap_count;
        expected_n    = expected;

        case (state)
            SYNC: begin
                expected_n = predict;
                synced_n   = 1'b1;
                state_n    = TRACK;
            end
            TRACK: begin
                // The match test is written as the positive case so that an
                // unknown in/enable falls through to the mismatch branch.
                if (in == expected) begin
                    expected_n = predict;
                    if (in == '1 && enable && wrap_count != '1)
                        wrap_count_n = wrap_count + 1'b1;
                end else begin
                    error_n = 1'b1;
                    if (error_count != '1)
                        error_count_n = error_count + 1'b1;
                    if (STICKY != 0) begin
                        state_n = FAULT;
                        fault_n = 1'b1;
                    end else begin
                        expected_n = predict;
                    end
                end
            end
            FAULT: begin
                // Terminal until reset; everything stays frozen.
            end
            default: begin
                state_n = SYNC;
            end
        endcase
    end

endmodule
